// File: rtl/delay_ctrl_pkg.sv
// Shared types for the delay parameter sequencer: FSM states, clamp floor and target bundle.
// cfg_t field widths track the sequencer's default ADDR_WIDTH / FEEDBACK_WIDTH.
package delay_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FADE,
    SWITCH,
    GLIDE
  } state_t;

  localparam int unsigned MIN_DELAY  = 1;
  localparam int unsigned CFG_ADDR_W = 16;
  localparam int unsigned CFG_FB_W   = 8;

  typedef struct packed {
    logic [CFG_ADDR_W-1:0] delay;
    logic [CFG_FB_W-1:0]   feedback;
    logic [7:0]            effect;
    logic                  mode;
  } cfg_t;

endpackage

// File: rtl/delay_param_sequencer_slew_step.sv
// Combinational slew: moves cur toward tgt by at most STEP, never overshooting.
module slew_step #(
  parameter int unsigned W    = 8,
  parameter int unsigned STEP = 1
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] tgt,
  output logic [W-1:0] next
);

  localparam logic [W-1:0] STEP_W = W'(STEP);

  always_comb begin
    next = cur;
    if (tgt > cur) begin
      next = ((tgt - cur) > STEP_W) ? cur + STEP_W : tgt;
    end else if (tgt < cur) begin
      next = ((cur - tgt) > STEP_W) ? cur - STEP_W : tgt;
    end
  end

endmodule

// File: rtl/delay_param_sequencer.sv
// Click-free parameter sequencer for delay_effect: slews targets per sample, fades before mode swap.
// Optional tap tempo enabled by defining DELAY_TAP_TEMPO_EN (adds the tap port).
module delay_param_sequencer
  import delay_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned FEEDBACK_WIDTH = 8,
  parameter int unsigned DELAY_STEP     = 1,
  parameter int unsigned DEFAULT_DELAY  = 4800,
  parameter int unsigned FEEDBACK_MAX   = 230
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_valid,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [ADDR_WIDTH-1:0]     cfg_delay,
  input  logic [FEEDBACK_WIDTH-1:0] cfg_feedback,
  input  logic [7:0]                cfg_effect,
  input  logic                      cfg_mode,
`ifdef DELAY_TAP_TEMPO_EN
  input  logic                      tap,
`endif
  output logic [ADDR_WIDTH-1:0]     delay_samples,
  output logic [FEEDBACK_WIDTH-1:0] feedback_amount,
  output logic [7:0]                effect_amount,
  output logic                      mode,
  output logic                      busy
);

  localparam logic [ADDR_WIDTH-1:0]     MIN_D = ADDR_WIDTH'(MIN_DELAY);
  localparam logic [ADDR_WIDTH-1:0]     DEF_D = ADDR_WIDTH'(DEFAULT_DELAY);
  localparam logic [FEEDBACK_WIDTH-1:0] FB_MX = FEEDBACK_WIDTH'(FEEDBACK_MAX);

  state_t state, state_next;
  cfg_t   tgt, cfg_in;
  logic   accept, tap_load, ready_nx, busy_nx;
  logic [ADDR_WIDTH-1:0]     tap_delay, delay_slewed, delay_nx;
  logic [FEEDBACK_WIDTH-1:0] fb_goal, fb_slewed, fb_nx;
  logic [7:0]                eff_goal, eff_slewed, eff_nx;

  assign accept = cfg_valid && cfg_ready;

  always_comb begin
    cfg_in.delay    = (cfg_delay == '0) ? MIN_D : cfg_delay;
    cfg_in.feedback = (cfg_feedback > FB_MX) ? FB_MX : cfg_feedback;
    cfg_in.effect   = cfg_effect;
    cfg_in.mode     = cfg_mode;
  end

`ifdef DELAY_TAP_TEMPO_EN
  logic [ADDR_WIDTH-1:0] tick_cnt;

  // Starts saturated so a tap before any reference tap cannot load a bogus interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '1;
    end else if (tap) begin
      tick_cnt <= '0;
    end else if (sample_valid && (tick_cnt != '1)) begin
      tick_cnt <= tick_cnt + ADDR_WIDTH'(1);
    end
  end

  assign tap_load  = tap && (state == IDLE) && !accept && (tick_cnt != '1);
  assign tap_delay = (tick_cnt == '0) ? MIN_D : tick_cnt;
`else
  assign tap_load  = 1'b0;
  assign tap_delay = '0;
`endif

  // FADE reuses the feedback/effect slews with a zero goal.
  assign fb_goal  = (state == FADE) ? '0 : tgt.feedback;
  assign eff_goal = (state == FADE) ? '0 : tgt.effect;

  slew_step #(.W(ADDR_WIDTH), .STEP(DELAY_STEP)) u_delay_slew (
    .cur(delay_samples), .tgt(tgt.delay), .next(delay_slewed)
  );
  slew_step #(.W(FEEDBACK_WIDTH), .STEP(1)) u_fb_slew (
    .cur(feedback_amount), .tgt(fb_goal), .next(fb_slewed)
  );
  slew_step #(.W(8), .STEP(1)) u_eff_slew (
    .cur(effect_amount), .tgt(eff_goal), .next(eff_slewed)
  );

  always_comb begin
    delay_nx = delay_samples;
    fb_nx    = feedback_amount;
    eff_nx   = effect_amount;
    if (sample_valid && (state == GLIDE)) delay_nx = delay_slewed;
    if (sample_valid && ((state == GLIDE) || (state == FADE))) begin
      fb_nx  = fb_slewed;
      eff_nx = eff_slewed;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept)        state_next = (cfg_mode != mode) ? FADE : GLIDE;
        else if (tap_load) state_next = GLIDE;
      end
      FADE:   if ((fb_nx == '0) && (eff_nx == '0)) state_next = SWITCH;
      SWITCH: state_next = GLIDE;
      GLIDE: begin
        if ((delay_nx == tgt.delay) && (fb_nx == tgt.feedback) && (eff_nx == tgt.effect))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_nx = (state_next == IDLE);
    busy_nx  = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ready       <= 1'b1;
      busy            <= 1'b0;
      delay_samples   <= DEF_D;
      feedback_amount <= '0;
      effect_amount   <= '0;
      mode            <= 1'b0;
      tgt             <= '{delay: DEF_D, feedback: '0, effect: '0, mode: 1'b0};
    end else begin
      cfg_ready       <= ready_nx;
      busy            <= busy_nx;
      delay_samples   <= delay_nx;
      feedback_amount <= fb_nx;
      effect_amount   <= eff_nx;
      if (state == SWITCH) mode <= tgt.mode;
      if (accept)        tgt       <= cfg_in;
      else if (tap_load) tgt.delay <= tap_delay;
    end
  end

endmodule
